// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types for the load/store memory stage.
//   state_e   - FSM states of lsu_mem (IDLE, REQ, WAIT_RSP)
//   op_e      - decoded execute-stage operation (NOP, LOAD, STORE)
//   decode_op - priority decode of the execute-stage control bits
package lsu_pkg;

  localparam int unsigned TAG_W = 5;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_REQ      = 2'd1,
    S_WAIT_RSP = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OP_NOP   = 2'd0,
    OP_LOAD  = 2'd1,
    OP_STORE = 2'd2
  } op_e;

  // NOP wins over LOAD, LOAD wins over STORE; nothing enabled is a NOP.
  function automatic op_e decode_op(input logic is_nop, input logic is_load,
                                    input logic wr_en);
    op_e op;
    op = OP_NOP;
    if (is_nop) begin
      op = OP_NOP;
    end else if (is_load) begin
      op = OP_LOAD;
    end else if (wr_en) begin
      op = OP_STORE;
    end
    return op;
  endfunction

endpackage

// File: rtl/lsu_mem.sv
// lsu_mem: single-outstanding load/store stage between execute and memory.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   in_valid/in_ready               execute handshake (ready only in IDLE)
//   is_load, is_nop, wr_en          operation control bits
//   rd_addr, wr_addr, wr_data       load address, store address and data
//   rd_tag                          load destination register
//   flush                           synchronous pipeline flush
//   mem_req_valid/mem_req_ready     memory request handshake
//   mem_we, mem_addr, mem_wdata     request payload (zero when not valid)
//   mem_rsp_valid, mem_rdata        load response
//   wb_valid, wb_rd, wb_data        one-cycle load writeback
//   misalign                        one-cycle misaligned-access pulse
module lsu_mem
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              is_load,
  input  logic              is_nop,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_en,
  input  logic [TAG_W-1:0]  rd_tag,
  input  logic              flush,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wb_valid,
  output logic [TAG_W-1:0]  wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              misalign
);

  state_e              state_q, state_d;
  logic                discard_q, discard_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic                req_valid_q, req_valid_d;
  logic                req_we_q, req_we_d;
  logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
  logic [DATA_W-1:0]   req_wdata_q, req_wdata_d;
  logic                wb_valid_q, wb_valid_d;
  logic [TAG_W-1:0]    wb_rd_q, wb_rd_d;
  logic [DATA_W-1:0]   wb_data_q, wb_data_d;
  logic                misalign_q, misalign_d;
  op_e                 op;
  logic [ADDR_W-1:0]   acc_addr;

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    discard_d   = discard_q;
    tag_d       = tag_q;
    req_valid_d = req_valid_q;
    req_we_d    = req_we_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    wb_valid_d  = 1'b0;
    wb_rd_d     = '0;
    wb_data_d   = '0;
    misalign_d  = 1'b0;
    op          = decode_op(is_nop, is_load, wr_en);
    acc_addr    = (op == OP_LOAD) ? rd_addr : wr_addr;

    unique case (state_q)
      S_IDLE: begin
        // A flush cycle swallows whatever execute presents.
        if (in_valid && !flush && (op != OP_NOP)) begin
          if (acc_addr[1:0] != 2'b00) begin
            misalign_d = 1'b1;
          end else begin
            state_d     = S_REQ;
            req_valid_d = 1'b1;
            req_we_d    = (op == OP_STORE);
            req_addr_d  = acc_addr;
            req_wdata_d = wr_data;
            tag_d       = rd_tag;
            discard_d   = 1'b0;
          end
        end
      end
      S_REQ: begin
        // Once memory has taken the request it is committed; a coincident
        // flush only suppresses the load writeback.
        if (mem_req_ready) begin
          req_valid_d = 1'b0;
          req_we_d    = 1'b0;
          req_addr_d  = '0;
          req_wdata_d = '0;
          if (req_we_q) begin
            state_d = S_IDLE;
          end else begin
            state_d   = S_WAIT_RSP;
            discard_d = flush;
          end
        end else if (flush) begin
          req_valid_d = 1'b0;
          req_we_d    = 1'b0;
          req_addr_d  = '0;
          req_wdata_d = '0;
          state_d     = S_IDLE;
        end
      end
      S_WAIT_RSP: begin
        if (flush) begin
          discard_d = 1'b1;
        end
        if (mem_rsp_valid) begin
          state_d   = S_IDLE;
          discard_d = 1'b0;
          if (!discard_q && !flush) begin
            wb_valid_d = 1'b1;
            wb_rd_d    = tag_q;
            wb_data_d  = mem_rdata;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      discard_q   <= 1'b0;
      tag_q       <= '0;
      req_valid_q <= 1'b0;
      req_we_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      discard_q   <= discard_d;
      tag_q       <= tag_d;
      req_valid_q <= req_valid_d;
      req_we_q    <= req_we_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      wb_valid_q  <= wb_valid_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
      misalign_q  <= misalign_d;
    end
  end

  // in_ready is a pure decode of the state flop.
  assign in_ready      = (state_q == S_IDLE);
  assign mem_req_valid = req_valid_q;
  assign mem_we        = req_we_q;
  assign mem_addr      = req_addr_q;
  assign mem_wdata     = req_wdata_q;
  assign wb_valid      = wb_valid_q;
  assign wb_rd         = wb_rd_q;
  assign wb_data       = wb_data_q;
  assign misalign      = misalign_q;

endmodule

// File: tb/tb_lsu_mem.sv
// tb_lsu_mem: scoreboard bench for lsu_mem with a randomized memory responder.
module tb_lsu_mem;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid, in_ready, is_load, is_nop, wr_en, flush;
  logic [AW-1:0] rd_addr, wr_addr, mem_addr;
  logic [DW-1:0] wr_data, mem_wdata, mem_rdata, wb_data;
  logic [4:0]    rd_tag, wb_rd;
  logic          mem_req_valid, mem_req_ready, mem_we, mem_rsp_valid;
  logic          wb_valid, misalign;

  lsu_mem #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .is_load(is_load), .is_nop(is_nop), .rd_addr(rd_addr), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_en(wr_en), .rd_tag(rd_tag), .flush(flush),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .misalign(misalign)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            cyc;
  } req_t;
  typedef struct {
    logic [4:0]    rd;
    logic [DW-1:0] data;
  } wb_t;

  req_t req_q[$];
  wb_t  wb_q[$];
  int   mis_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int req_cnt  = 0;
  int wb_cnt   = 0;
  int last_wb_cyc = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
  endtask

  // Memory image seen by loads.
  function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
    if (a == 32'h0000_0200) return 32'h1234_5678;
    return DW'(a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  // Reference decode: 0 = NOP, 1 = LOAD, 2 = STORE.
  function automatic int ref_kind(input logic nop, input logic ld, input logic we);
    if (nop) return 0;
    if (ld) return 1;
    if (we) return 2;
    return 0;
  endfunction

  // ---------------- memory responder ----------------
  int ready_cfg = 0;
  int rsp_cfg   = 0;
  bit noise_en  = 1'b0;
  int rdy_cnt   = -1;
  int rsp_cnt   = -1;
  logic [AW-1:0] rsp_addr;

  initial begin
    bit hs;
    logic hs_we;
    logic [AW-1:0] hs_addr;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rdata     = '0;
    rsp_addr      = '0;
    forever begin
      @(negedge clk);
      hs      = rst_n && mem_req_valid && mem_req_ready;
      hs_we   = mem_we;
      hs_addr = mem_addr;
      @(posedge clk);
      #2;
      mem_rsp_valid = 1'b0;
      mem_rdata     = '0;
      if (!rst_n) begin
        mem_req_ready = 1'b0;
        rdy_cnt = -1;
        rsp_cnt = -1;
      end else begin
        if (hs) begin
          mem_req_ready = 1'b0;
          rdy_cnt = -1;
          if (!hs_we) begin
            rsp_cnt  = (rsp_cfg < 0) ? int'($urandom_range(0, 3)) : rsp_cfg;
            rsp_addr = hs_addr;
          end
        end else if (!mem_req_valid) begin
          mem_req_ready = 1'b0;
          rdy_cnt = -1;
        end else if (!mem_req_ready) begin
          if (rdy_cnt < 0) rdy_cnt = (ready_cfg < 0) ? int'($urandom_range(0, 3)) : ready_cfg;
          if (rdy_cnt == 0) mem_req_ready = 1'b1;
          else rdy_cnt--;
        end
        if (rsp_cnt == 0) begin
          mem_rsp_valid = 1'b1;
          mem_rdata     = mem_fn(rsp_addr);
          rsp_cnt       = -1;
        end else if (rsp_cnt > 0) begin
          rsp_cnt--;
        end else if (noise_en && $urandom_range(0, 7) == 0) begin
          mem_rsp_valid = 1'b1;
          mem_rdata     = $urandom;
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  bit            req_active = 1'b0;
  logic          held_we;
  logic [AW-1:0] held_addr;
  logic [DW-1:0] held_wdata;

  always @(negedge clk) begin
    req_t e;
    wb_t  w;
    int   m;
    if (!rst_n) begin
      req_active = 1'b0;
    end else begin
      chk("ready_during_req", 64'(in_ready & mem_req_valid), 64'd0);
      if (!mem_req_valid) begin
        req_active = 1'b0;
        chk("req_idle_zero", 64'(mem_addr) | 64'(mem_wdata) | 64'(mem_we), 64'd0);
      end else if (!req_active) begin
        req_cnt++;
        chk("req_expected", 64'(req_q.size() > 0), 64'd1);
        if (req_q.size() > 0) begin
          e = req_q.pop_front();
          chk("req_we", 64'(mem_we), 64'(e.we));
          chk("req_addr", 64'(mem_addr), 64'(e.addr));
          chk("req_wdata", 64'(mem_wdata), 64'(e.wdata));
          chk("req_latency", 64'(cyc), 64'(e.cyc));
        end
        req_active = 1'b1;
        held_we    = mem_we;
        held_addr  = mem_addr;
        held_wdata = mem_wdata;
      end else begin
        chk("req_stable", {31'd0, mem_we, mem_addr} ^ {31'd0, held_we, held_addr}, 64'd0);
        chk("req_stable_wdata", 64'(mem_wdata), 64'(held_wdata));
      end
      if (wb_valid) begin
        wb_cnt++;
        last_wb_cyc = cyc;
        chk("wb_expected", 64'(wb_q.size() > 0), 64'd1);
        if (wb_q.size() > 0) begin
          w = wb_q.pop_front();
          chk("wb_rd", 64'(wb_rd), 64'(w.rd));
          chk("wb_data", 64'(wb_data), 64'(w.data));
        end
      end
      if (misalign) begin
        chk("misalign_expected", 64'(mis_q.size() > 0), 64'd1);
        if (mis_q.size() > 0) begin
          m = mis_q.pop_front();
          chk("misalign_cycle", 64'(cyc), 64'(m));
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 64'(in_ready), 64'd1);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_wb(input int target);
    int n = 0;
    while (wb_cnt < target && n < 60) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (wb_cnt < target) chk("wb_timeout", 64'(wb_cnt), 64'(target));
  endtask

  task automatic issue(input logic nop, input logic ld, input logic we,
                       input logic [AW-1:0] ra, input logic [AW-1:0] wa,
                       input logic [DW-1:0] wd, input logic [4:0] tag,
                       input bit exp_wb, output int acc);
    int kind;
    logic [AW-1:0] a;
    wait_ready();
    is_nop = nop; is_load = ld; wr_en = we;
    rd_addr = ra; wr_addr = wa; wr_data = wd; rd_tag = tag;
    in_valid = 1'b1;
    acc = cyc;
    kind = ref_kind(nop, ld, we);
    a = (kind == 1) ? ra : wa;
    if (kind != 0) begin
      if (a % 4 != 0) begin
        mis_q.push_back(acc + 1);
      end else begin
        req_q.push_back('{we: (kind == 2), addr: a, wdata: wd, cyc: acc + 1});
        if (kind == 1 && exp_wb) wb_q.push_back('{rd: tag, data: mem_fn(a)});
      end
    end
    @(negedge clk);
    in_valid = 1'b0; is_nop = 1'b0; is_load = 1'b0; wr_en = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int acc, w0, r0;
    logic [AW-1:0] ra, wa;
    in_valid = 0; is_load = 0; is_nop = 0; wr_en = 0; flush = 0;
    rd_addr = '0; wr_addr = '0; wr_data = '0; rd_tag = '0;

    #1;
    chk("rst_req_valid", 64'(mem_req_valid), 64'd0);
    chk("rst_wb_valid", 64'(wb_valid), 64'd0);
    chk("rst_misalign", 64'(misalign), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // Store, immediate ready: one write request, no writeback.
    w0 = wb_cnt; r0 = req_cnt;
    issue(1'b0, 1'b0, 1'b1, 32'h0, 32'h100, 32'hDEAD_BEEF, 5'd0, 1'b1, acc);
    wait_cycles(4);
    chk("store_req_count", 64'(req_cnt - r0), 64'd1);
    chk("store_no_wb", 64'(wb_cnt), 64'(w0));

    // Load with ready delayed 3 cycles.
    ready_cfg = 3; rsp_cfg = 1;
    w0 = wb_cnt;
    issue(1'b0, 1'b1, 1'b0, 32'h200, 32'h0, 32'h0, 5'd7, 1'b1, acc);
    wait_wb(w0 + 1);
    wait_cycles(3);
    chk("load_wb_once", 64'(wb_cnt), 64'(w0 + 1));

    // Minimum load latency: writeback three cycles after accept.
    ready_cfg = 0; rsp_cfg = 0;
    w0 = wb_cnt;
    issue(1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 32'h0, 5'd3, 1'b1, acc);
    wait_wb(w0 + 1);
    chk("load_min_latency", 64'(last_wb_cyc), 64'(acc + 3));

    // Misaligned load.
    wait_cycles(1);
    issue(1'b0, 1'b1, 1'b0, 32'h203, 32'h0, 32'h0, 5'd9, 1'b1, acc);
    chk("mis_pulse", 64'(misalign), 64'd1);
    chk("mis_no_req", 64'(mem_req_valid), 64'd0);
    chk("mis_in_ready", 64'(in_ready), 64'd1);

    // NOP takes priority over wr_en.
    w0 = wb_cnt; r0 = req_cnt;
    issue(1'b1, 1'b0, 1'b1, 32'h0, 32'h100, 32'h55, 5'd1, 1'b1, acc);
    wait_cycles(5);
    chk("nop_no_req", 64'(req_cnt), 64'(r0));
    chk("nop_no_wb", 64'(wb_cnt), 64'(w0));

    // Flush while the request is still waiting for ready.
    ready_cfg = 20;
    issue(1'b0, 1'b0, 1'b1, 32'h0, 32'h300, 32'h77, 5'd0, 1'b0, acc);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_req_drop", 64'(mem_req_valid), 64'd0);
    chk("flush_req_ready", 64'(in_ready), 64'd1);

    // Flush while waiting for a load response.
    ready_cfg = 0; rsp_cfg = 2;
    w0 = wb_cnt;
    issue(1'b0, 1'b1, 1'b0, 32'h80, 32'h0, 32'h0, 5'd4, 1'b0, acc);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    wait_cycles(8);
    chk("flush_wait_no_wb", 64'(wb_cnt), 64'(w0));
    chk("flush_wait_ready", 64'(in_ready), 64'd1);

    // Reset asserted while a request is pending.
    ready_cfg = 20;
    w0 = wb_cnt;
    issue(1'b0, 1'b1, 1'b0, 32'hC0, 32'h0, 32'h0, 5'd5, 1'b0, acc);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_mid_req_valid", 64'(mem_req_valid), 64'd0);
    chk("rst_mid_addr", 64'(mem_addr), 64'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    wait_cycles(10);
    chk("rst_mid_no_wb", 64'(wb_cnt), 64'(w0));
    chk("rst_mid_ready", 64'(in_ready), 64'd1);

    // Randomized traffic.
    ready_cfg = -1; rsp_cfg = -1; noise_en = 1'b1;
    for (int i = 0; i < 60; i++) begin
      ra = $urandom & 32'h0000_0FFF;
      wa = $urandom & 32'h0000_0FFF;
      if ($urandom_range(0, 3) != 0) ra[1:0] = 2'b00;
      if ($urandom_range(0, 3) != 0) wa[1:0] = 2'b00;
      issue(1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), ra, wa, $urandom, 5'($urandom_range(0, 31)),
            1'b1, acc);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    for (int n = 0; n < 200; n++) begin
      if (req_q.size() == 0 && wb_q.size() == 0 && mis_q.size() == 0 && in_ready) break;
      @(negedge clk);
    end
    noise_en = 1'b0;
    wait_cycles(2);
    chk("drain_req_q", 64'(req_q.size()), 64'd0);
    chk("drain_wb_q", 64'(wb_q.size()), 64'd0);
    chk("drain_mis_q", 64'(mis_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
